// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (port 0)
// and the address-generation/CSR path (port 1); one operation in flight, IDLE -> EXEC -> RESP.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_0,
  input  logic            req_valid_1,
  output logic            req_ready_0,
  output logic            req_ready_1,
  input  logic [XLEN-1:0] req_op1_0,
  input  logic [XLEN-1:0] req_op1_1,
  input  logic [XLEN-1:0] req_op2_0,
  input  logic [XLEN-1:0] req_op2_1,
  input  logic [3:0]      req_op_0,
  input  logic [3:0]      req_op_1,
  output logic            rsp_valid_0,
  output logic            rsp_valid_1,
  input  logic            rsp_ready_0,
  input  logic            rsp_ready_1,
  output logic [XLEN-1:0] rsp_result_0,
  output logic [XLEN-1:0] rsp_result_1,
  output logic [3:0]      rsp_flags_0,
  output logic [3:0]      rsp_flags_1,
  output logic            rsp_err_0,
  output logic            rsp_err_1,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_negative,
  input  logic            alu_overflow,
  input  logic            alu_carry,
  output logic            busy
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic            last_grant;
  logic            owner;
  logic            grant;
  logic            accept;
  logic [XLEN-1:0] op1_p0;
  logic [XLEN-1:0] op2_p0;
  logic [3:0]      op_p0;
  logic [XLEN-1:0] result_p1;
  logic [3:0]      flags_p1;
  logic            err_p1;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Port 1 wins when it is alone, or on a tie when port 0 had the last grant.
  assign grant  = req_valid_1 & (~req_valid_0 | ~last_grant);
  assign accept = req_ready_0 | req_ready_1;

  always_comb begin
    state_nx    = state;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    rsp_valid_0 = 1'b0;
    rsp_valid_1 = 1'b0;
    case (state)
      IDLE: begin
        req_ready_0 = req_valid_0 & ~grant;
        req_ready_1 = grant;
        if (req_valid_0 | req_valid_1) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        rsp_valid_0 = ~owner;
        rsp_valid_1 = owner;
        if (owner ? rsp_ready_1 : rsp_ready_0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Stage p0: operands latched on accept; stage p1: ALU outputs captured at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_p0     <= '0;
      op2_p0     <= '0;
      op_p0      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result_p1  <= '0;
      flags_p1   <= '0;
      err_p1     <= 1'b0;
    end else begin
      if (accept) begin
        op1_p0     <= grant ? req_op1_1 : req_op1_0;
        op2_p0     <= grant ? req_op2_1 : req_op2_0;
        op_p0      <= grant ? req_op_1  : req_op_0;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        // An illegal opcode leaves the ALU outputs undefined, so they are never captured.
        if (op_legal(op_p0)) begin
          result_p1 <= alu_result;
          flags_p1  <= {alu_zero, alu_negative, alu_overflow, alu_carry};
          err_p1    <= 1'b0;
        end else begin
          result_p1 <= '0;
          flags_p1  <= '0;
          err_p1    <= 1'b1;
        end
      end
    end
  end

  assign alu_operand1 = op1_p0;
  assign alu_operand2 = op2_p0;
  assign alu_op       = op_p0;
  assign busy         = (state != IDLE);

  assign rsp_result_0 = owner ? '0 : result_p1;
  assign rsp_flags_0  = owner ? '0 : flags_p1;
  assign rsp_err_0    = ~owner & err_p1;
  assign rsp_result_1 = owner ? result_p1 : '0;
  assign rsp_flags_1  = owner ? flags_p1  : '0;
  assign rsp_err_1    = owner & err_p1;

endmodule
